// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - shared constants, lane state enum and bit-timing helpers for the MIDI receiver
// Optional feature macro: MIDI_RX_FRAMING_CHECK_EN
package midi_pkg;

  localparam int MIDI_BAUD_DEFAULT = 31250;
  localparam int SYSCLK_F_DEFAULT  = 48000000;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef MIDI_RX_FRAMING_CHECK_EN
    , BREAK
`endif
  } lane_state_e;

  function automatic int clk_per_bit(input int sysclk_f, input int baud);
    return sysclk_f / baud;
  endfunction

  function automatic int half_bit(input int sysclk_f, input int baud);
    return clk_per_bit(sysclk_f, baud) / 2;
  endfunction

endpackage

// File: rtl/midi_rx_lane.sv
// rtl/midi_rx_lane.sv - one MIDI port: synchroniser, 8N1 deserialiser FSM and one-byte holding register
// Optional feature macro: MIDI_RX_FRAMING_CHECK_EN (stop-bit check and BREAK recovery)
module midi_rx_lane
  import midi_pkg::*;
#(
  parameter int BYTE_W      = 8,
  parameter int CLK_PER_BIT = 1536,
  parameter int HALF_BIT    = 768
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_async,
  input  logic              hold_clr,
  output logic [BYTE_W-1:0] hold_data,
  output logic              hold_full,
  output logic              overrun,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(CLK_PER_BIT + 1);
  localparam int BIT_W = $clog2(BYTE_W + 1);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BYTE_W - 1);

  logic              sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  lane_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              done_q, done_d;
  logic [BYTE_W-1:0] hold_data_q, hold_data_d;
  logic              hold_full_q, hold_full_d;
  logic              overrun_q, overrun_d;
`ifdef MIDI_RX_FRAMING_CHECK_EN
  logic              ferr_pend_q, ferr_pend_d;
  logic              frame_err_q, frame_err_d;
`endif

  always_comb begin
    sync1_d     = rx_async;
    sync2_d     = sync1_q;
    sync3_d     = sync2_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    done_d      = 1'b0;
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;
    overrun_d   = 1'b0;
`ifdef MIDI_RX_FRAMING_CHECK_EN
    ferr_pend_d = 1'b0;
    frame_err_d = ferr_pend_q;
`endif

    case (state_q)
      IDLE: begin
        if (sync3_q && !sync2_q) begin
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[BYTE_W-1:1]};
          if (bit_q == LAST_BIT) state_d = STOP;
          else                   bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        // Leaving at the stop-bit centre lets the next start edge be caught immediately.
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
`ifdef MIDI_RX_FRAMING_CHECK_EN
          if (sync2_q) begin
            done_d = 1'b1;
          end else begin
            ferr_pend_d = 1'b1;
            state_d     = BREAK;
          end
`else
          done_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef MIDI_RX_FRAMING_CHECK_EN
      BREAK: begin
        if (!sync2_q) begin
          cnt_d = '0;
        end else if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // A clear arriving with a new byte frees the slot for it, so that is not an overrun.
    if (done_q) begin
      if (hold_full_q && !hold_clr) begin
        overrun_d = 1'b1;
      end else begin
        hold_data_d = shift_q;
        hold_full_d = 1'b1;
      end
    end else if (hold_clr) begin
      hold_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      sync3_q     <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      done_q      <= 1'b0;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef MIDI_RX_FRAMING_CHECK_EN
      ferr_pend_q <= 1'b0;
      frame_err_q <= 1'b0;
`endif
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync3_q     <= sync3_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      done_q      <= done_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      overrun_q   <= overrun_d;
`ifdef MIDI_RX_FRAMING_CHECK_EN
      ferr_pend_q <= ferr_pend_d;
      frame_err_q <= frame_err_d;
`endif
    end
  end

  assign hold_data = hold_data_q;
  assign hold_full = hold_full_q;
  assign overrun   = overrun_q;
`ifdef MIDI_RX_FRAMING_CHECK_EN
  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: rtl/midi_rx_multi.sv
// rtl/midi_rx_multi.sv - NUM_PORTS MIDI lanes merged into one round-robin arbitrated valid/ready byte stream
// Optional feature macro: MIDI_RX_FRAMING_CHECK_EN (passed through to every lane)
module midi_rx_multi
  import midi_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int BYTE_W    = 8,
  parameter int MIDI_BAUD = MIDI_BAUD_DEFAULT,
  parameter int SYSCLK_F  = SYSCLK_F_DEFAULT,
  localparam int PORT_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [NUM_PORTS-1:0] midi_in,
  output logic [BYTE_W-1:0]    m_data,
  output logic [PORT_W-1:0]    m_port,
  output logic                 m_is_status,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [NUM_PORTS-1:0] overrun,
  output logic [NUM_PORTS-1:0] frame_err
);

  localparam int CPB  = clk_per_bit(SYSCLK_F, MIDI_BAUD);
  localparam int HALF = half_bit(SYSCLK_F, MIDI_BAUD);

  logic [BYTE_W-1:0]    hold_data [NUM_PORTS];
  logic [NUM_PORTS-1:0] hold_full;
  logic [NUM_PORTS-1:0] hold_clr;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lane
    midi_rx_lane #(
      .BYTE_W      (BYTE_W),
      .CLK_PER_BIT (CPB),
      .HALF_BIT    (HALF)
    ) u_lane (
      .clk       (sys_clk),
      .rst       (sys_rst),
      .rx_async  (midi_in[g]),
      .hold_clr  (hold_clr[g]),
      .hold_data (hold_data[g]),
      .hold_full (hold_full[g]),
      .overrun   (overrun[g]),
      .frame_err (frame_err[g])
    );
  end

  logic                m_valid_q, m_valid_d;
  logic [BYTE_W-1:0]   m_data_q, m_data_d;
  logic [PORT_W-1:0]   m_port_q, m_port_d;
  logic [PORT_W-1:0]   rr_q, rr_d;
  logic                grant_found;
  logic [PORT_W-1:0]   grant_idx, cand_idx;
  logic                load;

  // Search begins one past the last granted port so every waiting lane gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand_idx = PORT_W'((int'(rr_q) + i) % NUM_PORTS);
      if (!grant_found && hold_full[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    load      = !m_valid_q || m_ready;
    hold_clr  = '0;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_port_d  = m_port_q;
    rr_d      = rr_q;
    if (load) begin
      m_valid_d = grant_found;
      if (grant_found) begin
        hold_clr[grant_idx] = 1'b1;
        m_data_d            = hold_data[grant_idx];
        m_port_d            = grant_idx;
        rr_d                = grant_idx;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_port_q  <= '0;
      rr_q      <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_port_q  <= m_port_d;
      rr_q      <= rr_d;
    end
  end

  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign m_port      = m_port_q;
  assign m_is_status = m_data_q[BYTE_W-1];

endmodule

// File: tb/tb_midi_rx_multi.sv
// tb/tb_midi_rx_multi.sv - randomized self-checking bench for midi_rx_multi against a frame-schedule reference model
// Optional feature macro: MIDI_RX_FRAMING_CHECK_EN (selects expected stop-bit behaviour)
module tb_midi_rx_multi;

  localparam int NP     = 4;
  localparam int BW     = 8;
  localparam int PW     = 2;
  localparam int BAUD   = 31250;
  localparam int SYSF   = 2000000;
  localparam int CPB    = SYSF / BAUD;
  localparam int HALF   = CPB / 2;
  localparam int FRAME  = 10 * CPB;
  // Cycles from the first sampled low of a start bit to the holding-register load.
  localparam int ARRIVE = 3 + HALF + 9 * CPB;
`ifdef MIDI_RX_FRAMING_CHECK_EN
  localparam bit FCHK = 1'b1;
`else
  localparam bit FCHK = 1'b0;
`endif

  typedef struct {
    int port;
    int start;
    int data;
    bit stop_ok;
    int glitch;
  } frame_t;

  logic          sys_clk;
  logic          sys_rst;
  logic [NP-1:0] midi_in;
  logic [BW-1:0] m_data;
  logic [PW-1:0] m_port;
  logic          m_is_status;
  logic          m_valid;
  logic          m_ready;
  logic [NP-1:0] overrun;
  logic [NP-1:0] frame_err;

  midi_rx_multi #(
    .NUM_PORTS (NP),
    .BYTE_W    (BW),
    .MIDI_BAUD (BAUD),
    .SYSCLK_F  (SYSF)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .midi_in     (midi_in),
    .m_data      (m_data),
    .m_port      (m_port),
    .m_is_status (m_is_status),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .overrun     (overrun),
    .frame_err   (frame_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  frame_t        frames[$];
  logic [NP-1:0] force_low;
  int            cyc;
  int            rdy_mode;
  int            n_checks;
  int            n_pass;

  bit            md_valid;
  int            md_data;
  int            md_port;
  int            md_last;
  bit            h_full [NP];
  int            h_data [NP];
  logic [NP-1:0] exp_ovr;
  logic [NP-1:0] exp_ferr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
  endtask

  function automatic logic line_val(input int p, input int n);
    logic v;
    v = force_low[p] ? 1'b0 : 1'b1;
    foreach (frames[i]) begin
      if (frames[i].port == p && n >= frames[i].start) begin
        int k;
        k = n - frames[i].start;
        if (frames[i].glitch > 0) begin
          if (k < frames[i].glitch) v = 1'b0;
        end else if (k < FRAME) begin
          if (k < CPB)          v = 1'b0;
          else if (k < 9 * CPB) v = ((frames[i].data >> (k / CPB - 1)) & 1) != 0;
          else                  v = frames[i].stop_ok;
        end
      end
    end
    return v;
  endfunction

  task automatic add_frame(input int p, input int s, input int d, input bit ok, input int gl);
    frame_t f;
    f.port = p; f.start = s; f.data = d; f.stop_ok = ok; f.glitch = gl;
    frames.push_back(f);
  endtask

  task automatic model_step(input int n, input bit rdy, input bit rst);
    int g;
    exp_ovr  = '0;
    exp_ferr = '0;
    if (rst) begin
      md_valid = 1'b0; md_data = 0; md_port = 0; md_last = 0;
      for (int p = 0; p < NP; p++) h_full[p] = 1'b0;
    end else begin
      if (!md_valid || rdy) begin
        g = -1;
        for (int i = 1; i <= NP; i++) begin
          int c;
          c = (md_last + i) % NP;
          if (g < 0 && h_full[c]) g = c;
        end
        if (g >= 0) begin
          md_valid = 1'b1; md_data = h_data[g]; md_port = g; md_last = g;
          h_full[g] = 1'b0;
        end else begin
          md_valid = 1'b0;
        end
      end
      foreach (frames[i]) begin
        if (frames[i].glitch == 0 && frames[i].start + ARRIVE == n) begin
          int p;
          p = frames[i].port;
          if (frames[i].stop_ok || !FCHK) begin
            if (h_full[p]) exp_ovr[p] = 1'b1;
            else begin h_data[p] = frames[i].data; h_full[p] = 1'b1; end
          end else begin
            exp_ferr[p] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    cyc++;
    model_step(cyc, m_ready, sys_rst);
    @(negedge sys_clk);
    check("m_valid", m_valid, md_valid);
    if (md_valid) begin
      check("m_data", m_data, md_data);
      check("m_port", m_port, md_port);
      check("m_is_status", m_is_status, (md_data >> 7) & 1);
    end
    check("overrun", overrun, exp_ovr);
    check("frame_err", frame_err, exp_ferr);
    case (rdy_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    for (int p = 0; p < NP; p++) midi_in[p] = line_val(p, cyc + 1);
  endtask

  initial begin
    int s, first, nvalid, ovr_cnt, ferr_cnt;
    int ports_seen[$];
    int arb_exp[5];
    int nstart[NP];
    int last_end;

    n_checks = 0; n_pass = 0; cyc = 0;
    sys_rst = 1'b1; m_ready = 1'b0; rdy_mode = 0;
    force_low = '1; midi_in = '0;
    md_valid = 1'b0; md_data = 0; md_port = 0; md_last = 0;
    for (int p = 0; p < NP; p++) begin h_full[p] = 1'b0; h_data[p] = 0; end

    // Reset with every line held low, then released
    repeat (4) tick();
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_port", m_port, 0);
    check("rst_m_is_status", m_is_status, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_err", frame_err, 0);
    sys_rst = 1'b0;
    repeat (20) tick();
    force_low = '0;
    nvalid = 0;
    for (int k = 0; k < 300; k++) begin tick(); if (m_valid) nvalid++; end
    check("rst_hold_no_byte", nvalid, 0);

    // Single status byte on port 0
    rdy_mode = 1; m_ready = 1'b1;
    s = cyc + 5;
    add_frame(0, s, 8'h90, 1'b1, 0);
    first = -1; nvalid = 0;
    for (int k = 0; k < FRAME + 40; k++) begin
      tick();
      if (m_valid) begin
        nvalid++;
        if (first < 0) begin
          first = cyc;
          check("single_data", m_data, 8'h90);
          check("single_port", m_port, 0);
          check("single_status", m_is_status, 1);
        end
      end
    end
    check("single_latency", first - s, ARRIVE + 1);
    check("single_len", nvalid, 1);

    // Short low glitch on port 2
    add_frame(2, cyc + 5, 0, 1'b1, HALF / 2);
    nvalid = 0; ferr_cnt = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (m_valid) nvalid++;
      if (frame_err != 0) ferr_cnt++;
    end
    check("glitch_no_byte", nvalid, 0);
    check("glitch_no_ferr", ferr_cnt, 0);

    // Ties between ports 1 and 3, separated by a lone port-2 byte
    s = cyc + 5;
    add_frame(1, s, 8'h3C, 1'b1, 0);
    add_frame(3, s, 8'h7F, 1'b1, 0);
    add_frame(2, s + FRAME + 100, 8'h11, 1'b1, 0);
    add_frame(1, s + 2 * FRAME + 200, 8'h21, 1'b1, 0);
    add_frame(3, s + 2 * FRAME + 200, 8'h22, 1'b1, 0);
    for (int k = 0; k < 3 * FRAME + 300; k++) begin
      tick();
      if (m_valid) ports_seen.push_back(int'(m_port));
    end
    arb_exp = '{1, 3, 2, 3, 1};
    check("arb_count", ports_seen.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < ports_seen.size()) check("arb_order", ports_seen[i], arb_exp[i]);

    // Back-pressure: three bytes on port 0 with the consumer stalled
    rdy_mode = 0; m_ready = 1'b0;
    s = cyc + 5;
    add_frame(0, s, 8'h40, 1'b1, 0);
    add_frame(0, s + FRAME, 8'h41, 1'b1, 0);
    add_frame(0, s + 2 * FRAME, 8'h42, 1'b1, 0);
    ovr_cnt = 0;
    for (int k = 0; k < 3 * FRAME + 40; k++) begin
      tick();
      if (overrun[0]) ovr_cnt++;
    end
    check("ovr_pulses", ovr_cnt, 1);
    check("ovr_held_valid", m_valid, 1);
    check("ovr_held_data", m_data, 8'h40);
    rdy_mode = 1;
    for (int k = 0; k < 20; k++) tick();

    // Stop bit low, then a clean byte after the line has idled a full bit
    s = cyc + 5;
    add_frame(0, s, 8'h55, 1'b0, 0);
    add_frame(0, s + FRAME + CPB + 20, 8'h80, 1'b1, 0);
    nvalid = 0; ferr_cnt = 0;
    for (int k = 0; k < 2 * FRAME + CPB + 80; k++) begin
      tick();
      if (m_valid) nvalid++;
      if (frame_err[0]) ferr_cnt++;
    end
    check("ferr_pulses", ferr_cnt, FCHK ? 1 : 0);
    check("ferr_bytes", nvalid, FCHK ? 1 : 2);

    // Reset in the middle of a frame abandons it
    add_frame(1, cyc + 5, 8'hFF, 1'b1, 0);
    for (int k = 0; k < 200; k++) tick();
    sys_rst = 1'b1;
    frames.delete();
    repeat (3) tick();
    sys_rst = 1'b0;
    nvalid = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin tick(); if (m_valid) nvalid++; end
    check("midframe_rst_no_byte", nvalid, 0);

    // Random bytes on all ports with bursts of consumer stall
    last_end = 0;
    for (int p = 0; p < NP; p++) nstart[p] = cyc + 5 + $urandom_range(0, CPB * 4);
    for (int j = 0; j < 6; j++) begin
      for (int p = 0; p < NP; p++) begin
        add_frame(p, nstart[p], $urandom_range(0, 255), 1'b1, 0);
        if (nstart[p] + FRAME > last_end) last_end = nstart[p] + FRAME;
        nstart[p] = nstart[p] + FRAME + $urandom_range(0, 2 * CPB);
      end
    end
    while (cyc < last_end + 100) begin
      rdy_mode = $urandom_range(0, 2);
      for (int k = 0; k < 256; k++) tick();
    end
    rdy_mode = 1;
    for (int k = 0; k < 50; k++) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
